// File: rtl/axis_master_pkt_if.sv
// Bundles the backend push port and the AXI-Stream master bus of axis_master_pkt.
// Latency: none. This is wiring only.
// Backpressure: bk_ready and axis_tready carry the flow control in each direction.
interface axis_master_pkt_if #(
    parameter int DATA_W = 32,
    parameter int USER_W = 2,
    parameter int DEPTH  = 8
) ();
    localparam int STRB_W = DATA_W / 8;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    // Backend side
    logic              bk_valid;
    logic              bk_ready;
    logic [DATA_W-1:0] bk_data;
    logic [STRB_W-1:0] bk_tstrb;
    logic [STRB_W-1:0] bk_tkeep;
    logic [USER_W-1:0] bk_user;
    logic              bk_last;
    logic              bk_nordy;
    logic              bk_done;
    logic [LVL_W-1:0]  bk_level;

    // AXI-Stream side
    logic              axis_tvalid;
    logic [DATA_W-1:0] axis_tdata;
    logic [STRB_W-1:0] axis_tstrb;
    logic [STRB_W-1:0] axis_tkeep;
    logic              axis_tlast;
    logic [USER_W-1:0] axis_tuser;
    logic              axis_tready;

    // View taken by the block that owns the FIFO and drives the stream
    modport master (
        input  bk_valid, bk_data, bk_tstrb, bk_tkeep, bk_user, bk_last, axis_tready,
        output bk_ready, bk_nordy, bk_done, bk_level,
        output axis_tvalid, axis_tdata, axis_tstrb, axis_tkeep, axis_tlast, axis_tuser
    );

    // View taken by the surrounding logic: the backend plus the stream sink
    modport slave (
        output bk_valid, bk_data, bk_tstrb, bk_tkeep, bk_user, bk_last, axis_tready,
        input  bk_ready, bk_nordy, bk_done, bk_level,
        input  axis_tvalid, axis_tdata, axis_tstrb, axis_tkeep, axis_tlast, axis_tuser
    );
endinterface

// File: rtl/axis_master_pkt.sv
// AXI-Stream packet master fed through an internal first-word-fall-through FIFO.
// Latency: 1 cycle from a backend push to axis_tvalid.
// Backpressure: bk_ready drops only when the FIFO is full; sink stalls raise bk_nordy.
module axis_master_pkt #(
    parameter int DATA_W      = 32,
    parameter int USER_W      = 2,
    parameter int DEPTH       = 8,
    parameter int PKT_LEN     = 0,
    parameter int RDY_TIMEOUT = 5
) (
    input  logic                 axi_aclk,
    input  logic                 axi_areset,
    axis_master_pkt_if.master    bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic [STRB_W-1:0] keep;
        logic [USER_W-1:0] user;
        logic              last;
    } entry_t;

    typedef enum logic {
        IDLE,
        IN_PKT
    } state_t;

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;
    logic [7:0]        stall_cnt;
    logic [7:0]        stall_nxt;
    state_t            state;
    logic              done_q;
    logic              nordy_q;
    logic              push;
    logic              pop;
    logic              last_tag;
    entry_t            head;
    entry_t            wr_entry;

    // Full blocks the write even if the head pops in the same cycle
    assign bus.bk_ready    = (level < LVL_W'(DEPTH)) && !axi_areset;
    assign push            = bus.bk_valid && bus.bk_ready;
    assign bus.axis_tvalid = (level != '0);
    assign pop             = bus.axis_tvalid && bus.axis_tready;
    assign head            = mem[rd_ptr];

    generate
        if (PKT_LEN == 0) begin : g_ext_last
            assign last_tag = bus.bk_last;
        end else begin : g_cnt_last
            localparam int CNT_W = $clog2(PKT_LEN + 1);
            logic [CNT_W-1:0] in_beat_cnt;

            assign last_tag = (in_beat_cnt == CNT_W'(PKT_LEN - 1));

            // Count pushed beats; the PKT_LEN-th beat is tagged last and the count restarts
            always_ff @(posedge axi_aclk) begin
                if (axi_areset) begin
                    in_beat_cnt <= '0;
                end else if (push) begin
                    in_beat_cnt <= last_tag ? '0 : in_beat_cnt + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign wr_entry = '{data: bus.bk_data, strb: bus.bk_tstrb, keep: bus.bk_tkeep,
                        user: bus.bk_user, last: last_tag};

    // Payload storage; contents are meaningless once the pointers are reset
    always_ff @(posedge axi_aclk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the level unchanged
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Next stall count: grows while the sink holds off a valid beat, saturating at 255
    always_comb begin
        stall_nxt = 8'd0;
        if (bus.axis_tvalid && !bus.axis_tready) begin
            stall_nxt = (stall_cnt == 8'hFF) ? 8'hFF : stall_cnt + 8'd1;
        end
    end

    // Stall counter and its registered timeout flag
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            stall_cnt <= 8'd0;
            nordy_q   <= 1'b0;
        end else begin
            stall_cnt <= stall_nxt;
            nordy_q   <= (stall_nxt >= 8'(RDY_TIMEOUT));
        end
    end

    // Packet tracker; every tlast pop gives a one-cycle done pulse on the next cycle
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            done_q <= pop && head.last;
            case (state)
                IDLE:    if (pop && !head.last) state <= IN_PKT;
                IN_PKT:  if (pop && head.last)  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.axis_tdata = head.data;
    assign bus.axis_tstrb = head.strb;
    assign bus.axis_tkeep = head.keep;
    assign bus.axis_tuser = head.user;
    assign bus.axis_tlast = bus.axis_tvalid && head.last;
    assign bus.bk_done    = done_q;
    assign bus.bk_nordy   = nordy_q;
    assign bus.bk_level   = level;
endmodule

// File: tb/tb_axis_master_pkt.sv
// Bench for axis_master_pkt: one instance with external tlast, one generating tlast every 4 beats.
// Both see the same stimulus; a scoreboard queue holds expected beats until they pop.
// Handshake, level, done and stall expectations come from a small reference model.
module tb_axis_master_pkt;
    localparam int DATA_W      = 32;
    localparam int USER_W      = 2;
    localparam int DEPTH       = 8;
    localparam int RDY_TIMEOUT = 5;
    localparam int PKT_B       = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axis_master_pkt_if #(.DATA_W(DATA_W), .USER_W(USER_W), .DEPTH(DEPTH)) ifa ();
    axis_master_pkt_if #(.DATA_W(DATA_W), .USER_W(USER_W), .DEPTH(DEPTH)) ifb ();

    axis_master_pkt #(.DATA_W(DATA_W), .USER_W(USER_W), .DEPTH(DEPTH),
                      .PKT_LEN(0), .RDY_TIMEOUT(RDY_TIMEOUT))
        dut_a (.axi_aclk(clk), .axi_areset(rst), .bus(ifa.master));

    axis_master_pkt #(.DATA_W(DATA_W), .USER_W(USER_W), .DEPTH(DEPTH),
                      .PKT_LEN(PKT_B), .RDY_TIMEOUT(RDY_TIMEOUT))
        dut_b (.axi_aclk(clk), .axi_areset(rst), .bus(ifb.master));

    typedef struct {
        logic [31:0] d;
        logic [3:0]  s;
        logic [3:0]  k;
        logic [1:0]  u;
        logic        la;
        logic        lb;
    } beat_t;

    beat_t sb[$];
    int    n_chk = 0;
    int    n_fail = 0;
    int    m_lvl = 0;
    int    m_stall = 0;
    int    m_cntb = 0;
    logic  m_done_a = 1'b0;
    logic  m_done_b = 1'b0;
    logic  m_nordy = 1'b0;
    int    pop_cnt = 0;
    int    done_cnt_a = 0;
    int    done_cnt_b = 0;
    logic        v_valid = 1'b0;
    logic        v_last = 1'b0;
    logic        v_tready = 1'b0;
    logic [31:0] v_data = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic valid, input logic [31:0] data, input logic last,
                         input logic tready);
        v_valid = valid; v_data = data; v_last = last; v_tready = tready;
        ifa.bk_valid = valid;        ifb.bk_valid = valid;
        ifa.bk_data  = data;         ifb.bk_data  = data;
        ifa.bk_tstrb = data[3:0];    ifb.bk_tstrb = data[3:0];
        ifa.bk_tkeep = data[7:4];    ifb.bk_tkeep = data[7:4];
        ifa.bk_user  = data[9:8];    ifb.bk_user  = data[9:8];
        ifa.bk_last  = last;         ifb.bk_last  = 1'b0;
        ifa.axis_tready = tready;    ifb.axis_tready = tready;
    endtask

    // Check the current cycle against the model, then advance model and clock by one cycle
    task automatic tick();
        logic  push;
        logic  pop;
        beat_t b;
        #1;
        chk("bk_ready_a", ifa.bk_ready, (!rst && m_lvl < DEPTH));
        chk("bk_ready_b", ifb.bk_ready, (!rst && m_lvl < DEPTH));
        chk("tvalid_a", ifa.axis_tvalid, (m_lvl != 0));
        chk("tvalid_b", ifb.axis_tvalid, (m_lvl != 0));
        chk("level_a", ifa.bk_level, m_lvl);
        chk("level_b", ifb.bk_level, m_lvl);
        chk("done_a", ifa.bk_done, m_done_a);
        chk("done_b", ifb.bk_done, m_done_b);
        chk("nordy_a", ifa.bk_nordy, m_nordy);
        chk("nordy_b", ifb.bk_nordy, m_nordy);
        if (m_lvl != 0 && sb.size() != 0) begin
            b = sb[0];
            chk("tdata_a", ifa.axis_tdata, b.d);
            chk("tstrb_a", ifa.axis_tstrb, b.s);
            chk("tkeep_a", ifa.axis_tkeep, b.k);
            chk("tuser_a", ifa.axis_tuser, b.u);
            chk("tlast_a", ifa.axis_tlast, b.la);
            chk("tdata_b", ifb.axis_tdata, b.d);
            chk("tlast_b", ifb.axis_tlast, b.lb);
        end
        if (ifa.bk_done === 1'b1) done_cnt_a++;
        if (ifb.bk_done === 1'b1) done_cnt_b++;
        if (rst) begin
            sb.delete();
            m_lvl = 0; m_stall = 0; m_cntb = 0;
            m_done_a = 1'b0; m_done_b = 1'b0; m_nordy = 1'b0;
        end else begin
            push = v_valid && (m_lvl < DEPTH);
            pop  = (m_lvl != 0) && v_tready;
            m_done_a = 1'b0;
            m_done_b = 1'b0;
            if (pop) begin
                b = sb.pop_front();
                pop_cnt++;
                m_done_a = b.la;
                m_done_b = b.lb;
            end
            if (m_lvl != 0 && !v_tready) m_stall = (m_stall < 255) ? m_stall + 1 : 255;
            else                         m_stall = 0;
            m_nordy = (m_stall >= RDY_TIMEOUT);
            if (push) begin
                b.d = v_data; b.s = v_data[3:0]; b.k = v_data[7:4]; b.u = v_data[9:8];
                b.la = v_last;
                b.lb = (m_cntb == PKT_B - 1);
                m_cntb = b.lb ? 0 : m_cntb + 1;
                sb.push_back(b);
            end
            m_lvl = m_lvl + int'(push) - int'(pop);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input logic [31:0] data, input logic last, input logic tready);
        logic acc;
        drive(1'b1, data, last, tready);
        for (int i = 0; i < 20; i++) begin
            acc = !rst && (m_lvl < DEPTH);
            tick();
            if (acc) return;
        end
        chk("push_timeout", ifa.bk_ready, 1'b1);
    endtask

    task automatic drain();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 30 && m_lvl != 0; i++) tick();
        tick();
        chk("drain_level", ifa.bk_level, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_nordy;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single-beat packet
        drive(1'b1, 32'hA5A5A5A5, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t1_tdata", ifa.axis_tdata, 32'hA5A5A5A5);
        chk("t1_tlast", ifa.axis_tlast, 1'b1);
        tick();
        chk("t1_done", ifa.bk_done, 1'b1);
        tick();
        chk("t1_level", ifa.bk_level, 0);

        // Fill to full with the sink stalled, then stream through many pointer wraps
        pop_cnt = 0;
        for (int i = 0; i < 8; i++) push_beat(32'(i), 1'b0, 1'b0);
        chk("t2_full_level", ifa.bk_level, 8);
        chk("t2_full_ready", ifa.bk_ready, 1'b0);
        drive(1'b1, 32'h8, 1'b0, 1'b0);
        tick();
        chk("t2_no_accept", ifa.bk_level, 8);
        for (int i = 8; i < 16; i++) push_beat(32'(i), 1'b0, 1'b1);
        drain();
        chk("t2_pop_count", pop_cnt, 16);

        // Stall timeout with a single queued beat
        push_beat(32'h0000_0C3C, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        first_nordy = 0;
        for (int k = 1; k <= 12; k++) begin
            if (first_nordy == 0 && ifa.bk_nordy === 1'b1) first_nordy = k;
            tick();
        end
        chk("t3_nordy_cycle", first_nordy, 6);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("t3_nordy_clear", ifa.bk_nordy, 1'b0);
        tick();

        // Generated tlast every 4 beats on instance B
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        done_cnt_a = 0;
        done_cnt_b = 0;
        for (int i = 0; i < 10; i++) push_beat(32'h100 + 32'(i), 1'b0, 1'b1);
        drain();
        chk("t4_done_b", done_cnt_b, 2);
        chk("t4_done_a", done_cnt_a, 0);

        // Simultaneous push and pop at constant level
        for (int i = 0; i < 3; i++) push_beat(32'h200 + 32'(i), 1'b0, 1'b0);
        for (int i = 3; i < 23; i++) begin
            drive(1'b1, 32'h200 + 32'(i), 1'b0, 1'b1);
            chk("t5_level", ifa.bk_level, 3);
            tick();
        end
        drain();

        // Reset in the middle of a packet
        for (int i = 0; i < 6; i++) push_beat(32'h2A0 + 32'(i), 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("t6_level_before", ifa.bk_level, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_tvalid", ifa.axis_tvalid, 1'b0);
        chk("t6_level", ifa.bk_level, 0);
        chk("t6_done", ifa.bk_done, 1'b0);
        chk("t6_nordy", ifa.bk_nordy, 1'b0);
        tick();
        done_cnt_a = 0;
        push_beat(32'h300, 1'b0, 1'b1);
        push_beat(32'h301, 1'b0, 1'b1);
        push_beat(32'h302, 1'b1, 1'b1);
        drain();
        chk("t6_done_count", done_cnt_a, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
